// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the single data_memory port: one registered strobe cycle
// per access, then a one-cycle acknowledge with read data to the winning requester.
//
// state  | meaning
// IDLE   | no access in flight; sample requests and grant one
// ACCESS | mem strobe asserted for exactly this cycle; read data sampled at its closing edge
// DONE   | owner's ack asserted for exactly this cycle
module data_memory_arbiter #(
    parameter int ROUND_ROBIN      = 1,
    parameter int RESET_PRIORITY_B = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req_in,
    input  logic [31:0] a_addr_in,
    input  logic [31:0] a_writedata_in,
    input  logic        a_we_in,
    input  logic [1:0]  a_size_in,
    output logic        a_ack_out,
    output logic [31:0] a_readdata_out,
    input  logic        b_req_in,
    input  logic [31:0] b_addr_in,
    input  logic [31:0] b_writedata_in,
    input  logic        b_we_in,
    input  logic [1:0]  b_size_in,
    output logic        b_ack_out,
    output logic [31:0] b_readdata_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_writedata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    output logic [1:0]  mem_size_out,
    input  logic [31:0] mem_readdata_in,
    output logic        busy_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic LP_RR          = (ROUND_ROBIN != 0);
    localparam logic LP_RST_PRIO_B  = (ROUND_ROBIN != 0) && (RESET_PRIORITY_B != 0);

    state_t      r_state;
    logic        r_owner_b;
    logic        r_prio_b;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_re;
    logic        r_mem_we;
    logic [1:0]  r_mem_size;

    // B wins when it is alone, or on a tie when it holds round-robin priority.
    logic w_grant_b;
    logic w_req_any;
    logic w_win_we;
    assign w_grant_b = b_req_in && (!a_req_in || (LP_RR && r_prio_b));
    assign w_req_any = a_req_in || b_req_in;
    assign w_win_we  = w_grant_b ? b_we_in : a_we_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner_b   <= 1'b0;
            r_prio_b    <= LP_RST_PRIO_B;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= 32'h0;
            r_b_rdata   <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    if (w_req_any) begin
                        r_owner_b   <= w_grant_b;
                        r_mem_addr  <= w_grant_b ? b_addr_in      : a_addr_in;
                        r_mem_wdata <= w_grant_b ? b_writedata_in : a_writedata_in;
                        r_mem_size  <= w_grant_b ? b_size_in      : a_size_in;
                        r_mem_we    <= w_win_we;
                        r_mem_re    <= !w_win_we;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_mem_re) begin
                        if (r_owner_b) r_b_rdata <= mem_readdata_in;
                        else           r_a_rdata <= mem_readdata_in;
                    end
                    r_mem_addr  <= 32'h0;
                    r_mem_wdata <= 32'h0;
                    r_mem_size  <= 2'b00;
                    r_mem_re    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_a_ack     <= !r_owner_b;
                    r_b_ack     <= r_owner_b;
                    if (LP_RR) r_prio_b <= !r_owner_b;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_ack_out         = r_a_ack;
    assign b_ack_out         = r_b_ack;
    assign a_readdata_out    = r_a_rdata;
    assign b_readdata_out    = r_b_rdata;
    assign mem_addr_out      = r_mem_addr;
    assign mem_writedata_out = r_mem_wdata;
    assign mem_re_out        = r_mem_re;
    assign mem_we_out        = r_mem_we;
    assign mem_size_out      = r_mem_size;
    assign busy_out          = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: stimulus pushes expected strobes/acks, negedge monitors pop and compare.
module tb_data_memory_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        a_req_in = 0, a_we_in = 0, b_req_in = 0, b_we_in = 0;
    logic [31:0] a_addr_in = 0, a_writedata_in = 0, b_addr_in = 0, b_writedata_in = 0;
    logic [1:0]  a_size_in = 0, b_size_in = 0;
    logic        a_ack_out, b_ack_out, mem_re_out, mem_we_out, busy_out;
    logic [31:0] a_readdata_out, b_readdata_out, mem_addr_out, mem_writedata_out, mem_readdata_in;
    logic [1:0]  mem_size_out;

    data_memory_arbiter #(.ROUND_ROBIN(1), .RESET_PRIORITY_B(0)) u_dut (
        .clock(clock), .reset(reset),
        .a_req_in(a_req_in), .a_addr_in(a_addr_in), .a_writedata_in(a_writedata_in),
        .a_we_in(a_we_in), .a_size_in(a_size_in), .a_ack_out(a_ack_out), .a_readdata_out(a_readdata_out),
        .b_req_in(b_req_in), .b_addr_in(b_addr_in), .b_writedata_in(b_writedata_in),
        .b_we_in(b_we_in), .b_size_in(b_size_in), .b_ack_out(b_ack_out), .b_readdata_out(b_readdata_out),
        .mem_addr_out(mem_addr_out), .mem_writedata_out(mem_writedata_out), .mem_re_out(mem_re_out),
        .mem_we_out(mem_we_out), .mem_size_out(mem_size_out), .mem_readdata_in(mem_readdata_in),
        .busy_out(busy_out)
    );

    // Fixed-priority instance used for the starvation scenario.
    logic        f_a_req = 0, f_b_req = 0;
    logic [31:0] f_a_addr = 32'h10000000, f_b_addr = 32'h7ffff000, f_zero32 = 32'h0;
    logic        f_zero1 = 1'b0;
    logic [1:0]  f_size = 2'b10;
    logic        f_a_ack, f_b_ack, f_mem_re, f_mem_we, f_busy;
    logic [31:0] f_a_rd, f_b_rd, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [1:0]  f_mem_size;

    data_memory_arbiter #(.ROUND_ROBIN(0), .RESET_PRIORITY_B(0)) u_dut_fp (
        .clock(clock), .reset(reset),
        .a_req_in(f_a_req), .a_addr_in(f_a_addr), .a_writedata_in(f_zero32),
        .a_we_in(f_zero1), .a_size_in(f_size), .a_ack_out(f_a_ack), .a_readdata_out(f_a_rd),
        .b_req_in(f_b_req), .b_addr_in(f_b_addr), .b_writedata_in(f_zero32),
        .b_we_in(f_zero1), .b_size_in(f_size), .b_ack_out(f_b_ack), .b_readdata_out(f_b_rd),
        .mem_addr_out(f_mem_addr), .mem_writedata_out(f_mem_wdata), .mem_re_out(f_mem_re),
        .mem_we_out(f_mem_we), .mem_size_out(f_mem_size), .mem_readdata_in(f_mem_rdata),
        .busy_out(f_busy)
    );

    assign f_mem_rdata = !f_mem_re ? 32'h0 :
                         (f_mem_addr == 32'h10000000) ? 32'h11110000 :
                         (f_mem_addr == 32'h7ffff000) ? 32'h22220000 : 32'h0;

    // Small data_memory model; index 7 is the unmapped slot and always reads 0.
    logic [31:0] ram [0:7] = '{32'h0, 32'h11110000, 32'h22220000, 32'h000000A5,
                               32'h33330020, 32'h0, 32'h0, 32'h0};

    function automatic logic [2:0] ram_idx(input logic [31:0] addr);
        case (addr)
            32'h10000010: return 3'd0;
            32'h10000000: return 3'd1;
            32'h7ffff000: return 3'd2;
            32'hffff0004: return 3'd3;
            32'h10000020: return 3'd4;
            32'h7ffff004: return 3'd5;
            default:      return 3'd7;
        endcase
    endfunction

    always @(posedge clock)
        if (mem_we_out && ram_idx(mem_addr_out) != 3'd7) ram[ram_idx(mem_addr_out)] <= mem_writedata_out;

    assign mem_readdata_in = mem_re_out ? ram[ram_idx(mem_addr_out)] : 32'h0;

    typedef struct {
        logic        owner_b;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
    } txn_t;

    txn_t strobe_q[$];
    txn_t ack_q[$];
    txn_t fack_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the round-robin instance.
    logic [31:0] exp_a_rd = 32'h0;
    logic [31:0] exp_b_rd = 32'h0;
    always @(negedge clock) begin
        txn_t t;
        if (mon_en) begin
            if (mem_re_out || mem_we_out) begin
                if (strobe_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: addr %h re %b we %b, expected no strobe", mem_addr_out, mem_re_out, mem_we_out);
                end else begin
                    t = strobe_q.pop_front();
                    check32("strobe_addr", mem_addr_out, t.addr);
                    check32("strobe_we", {31'b0, mem_we_out}, {31'b0, t.we});
                    check32("strobe_re", {31'b0, mem_re_out}, {31'b0, !t.we});
                    check32("strobe_wdata", mem_writedata_out, t.wdata);
                    check32("strobe_size", {30'b0, mem_size_out}, {30'b0, t.size});
                    check32("strobe_busy", {31'b0, busy_out}, 32'd1);
                end
            end else begin
                check32("quiet_addr", mem_addr_out, 32'h0);
                check32("quiet_wdata", mem_writedata_out, 32'h0);
                check32("quiet_size", {30'b0, mem_size_out}, 32'h0);
            end
            if (a_ack_out && b_ack_out) begin
                checks++; errors++;
                $display("FAIL both_acks: a_ack %b b_ack %b, expected at most one", a_ack_out, b_ack_out);
            end else if (a_ack_out || b_ack_out) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: a_ack %b b_ack %b, expected none", a_ack_out, b_ack_out);
                end else begin
                    t = ack_q.pop_front();
                    check32("ack_owner", {31'b0, b_ack_out}, {31'b0, t.owner_b});
                    if (!t.we) begin
                        if (t.owner_b) exp_b_rd = t.rdata;
                        else           exp_a_rd = t.rdata;
                    end
                    check32("a_readdata", a_readdata_out, exp_a_rd);
                    check32("b_readdata", b_readdata_out, exp_b_rd);
                end
            end
            if (reset) begin
                exp_a_rd = 32'h0;
                exp_b_rd = 32'h0;
            end
        end
    end

    // Monitor for the fixed-priority instance.
    always @(negedge clock) begin
        txn_t t;
        if (mon_en && (f_a_ack || f_b_ack)) begin
            if (fack_q.size() == 0 || (f_a_ack && f_b_ack)) begin
                checks++; errors++;
                $display("FAIL fp_unexpected_ack: a_ack %b b_ack %b", f_a_ack, f_b_ack);
            end else begin
                t = fack_q.pop_front();
                check32("fp_ack_owner", {31'b0, f_b_ack}, {31'b0, t.owner_b});
                check32("fp_readdata", t.owner_b ? f_b_rd : f_a_rd, t.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        a_req_in = 0; b_req_in = 0; f_a_req = 0; f_b_req = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic owner_b, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic [31:0] rdata);
        txn_t t;
        t.owner_b = owner_b; t.we = we; t.addr = addr; t.wdata = wdata; t.size = size; t.rdata = rdata;
        strobe_q.push_back(t);
        ack_q.push_back(t);
    endtask

    // Counts negedges until the chosen ack (any when which==2); 0 means timeout.
    task automatic wait_ack(input int which, output int n);
        bit got = 0;
        n = 0;
        while (!got && n < 12) begin
            @(negedge clock);
            n++;
            got = (which == 0) ? a_ack_out : (which == 1) ? b_ack_out : (a_ack_out || b_ack_out);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected one within 3", n);
            n = 0;
        end
    endtask

    task automatic wait_fack(output int n);
        bit got = 0;
        n = 0;
        while (!got && n < 12) begin
            @(negedge clock);
            n++;
            got = f_a_ack || f_b_ack;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL fp_ack_timeout: no ack after %0d cycles", n);
            n = 0;
        end
    endtask

    task automatic do_access(input logic owner_b, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic [31:0] rdata);
        int n;
        push(owner_b, we, addr, wdata, size, rdata);
        if (owner_b) begin
            b_addr_in = addr; b_writedata_in = wdata; b_we_in = we; b_size_in = size; b_req_in = 1;
        end else begin
            a_addr_in = addr; a_writedata_in = wdata; a_we_in = we; a_size_in = size; a_req_in = 1;
        end
        wait_ack(owner_b ? 1 : 0, n);
        check32("access_latency", n, 32'd3);
        tick();
        a_req_in = 0; b_req_in = 0; a_we_in = 0; b_we_in = 0;
        a_writedata_in = 0; b_writedata_in = 0;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clock);
        check32({tag, "_a_ack"}, {31'b0, a_ack_out}, 32'd0);
        check32({tag, "_b_ack"}, {31'b0, b_ack_out}, 32'd0);
        check32({tag, "_re_we"}, {30'b0, mem_re_out, mem_we_out}, 32'd0);
        check32({tag, "_a_rd"}, a_readdata_out, 32'h0);
        check32({tag, "_b_rd"}, b_readdata_out, 32'h0);
        check32({tag, "_busy"}, {31'b0, busy_out}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        apply_reset();
        mon_en = 1'b1;
        check_quiet("reset");

        // Single A write then read back.
        do_access(0, 1, 32'h10000010, 32'hDEADBEEF, 2'b11, 32'h0);
        do_access(0, 0, 32'h10000010, 32'h0, 2'b11, 32'hDEADBEEF);

        // Round-robin contention: A,B,A,B with 3-cycle spacing.
        apply_reset();
        push(0, 0, 32'h10000000, 32'h0, 2'b10, 32'h11110000);
        push(1, 0, 32'h7ffff000, 32'h0, 2'b10, 32'h22220000);
        push(0, 0, 32'h10000000, 32'h0, 2'b10, 32'h11110000);
        push(1, 0, 32'h7ffff000, 32'h0, 2'b10, 32'h22220000);
        a_addr_in = 32'h10000000; a_size_in = 2'b10; a_we_in = 0; a_req_in = 1;
        b_addr_in = 32'h7ffff000; b_size_in = 2'b10; b_we_in = 0; b_req_in = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(2, n);
            check32("rr_spacing", n, 32'd3);
        end
        tick();
        a_req_in = 0; b_req_in = 0;

        // Fixed priority: A starves B until A drops.
        apply_reset();
        for (int k = 0; k < 3; k++) fack_q.push_back('{1'b0, 1'b0, 32'h10000000, 32'h0, 2'b10, 32'h11110000});
        fack_q.push_back('{1'b1, 1'b0, 32'h7ffff000, 32'h0, 2'b10, 32'h22220000});
        f_a_req = 1; f_b_req = 1;
        for (int k = 0; k < 3; k++) begin
            wait_fack(n);
            check32("fp_spacing", n, 32'd3);
        end
        tick();
        f_a_req = 0;
        wait_fack(n);
        check32("fp_b_after_drop", n, 32'd3);
        tick();
        f_b_req = 0;

        // Serial MMIO read by B: one strobe, address only during ACCESS.
        apply_reset();
        do_access(1, 0, 32'hffff0004, 32'h0, 2'b10, 32'h000000A5);

        // Reset during ACCESS: write still lands, no ack, readdata cleared.
        apply_reset();
        do_access(0, 0, 32'h10000000, 32'h0, 2'b10, 32'h11110000);
        strobe_q.push_back('{1'b0, 1'b1, 32'h7ffff004, 32'hCAFEF00D, 2'b11, 32'h0});
        a_addr_in = 32'h7ffff004; a_writedata_in = 32'hCAFEF00D; a_we_in = 1; a_size_in = 2'b11; a_req_in = 1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; a_req_in = 0; a_we_in = 0; a_writedata_in = 0;
        #1;
        check_quiet("post_reset");
        do_access(0, 0, 32'h7ffff004, 32'h0, 2'b11, 32'hCAFEF00D);

        // Back-to-back: held req with a new address; busy low only in the IDLE gap.
        apply_reset();
        push(0, 0, 32'h10000010, 32'h0, 2'b11, 32'hDEADBEEF);
        push(0, 0, 32'h10000020, 32'h0, 2'b11, 32'h33330020);
        a_addr_in = 32'h10000010; a_size_in = 2'b11; a_we_in = 0; a_req_in = 1;
        wait_ack(0, n);
        check32("b2b_first_latency", n, 32'd3);
        tick();
        a_addr_in = 32'h10000020;
        @(negedge clock);
        check32("b2b_gap_busy", {31'b0, busy_out}, 32'd0);
        @(negedge clock);
        check32("b2b_access_busy", {31'b0, busy_out}, 32'd1);
        check32("b2b_access_re", {31'b0, mem_re_out}, 32'd1);
        @(negedge clock);
        check32("b2b_second_ack", {31'b0, a_ack_out}, 32'd1);
        check32("b2b_done_busy", {31'b0, busy_out}, 32'd1);
        tick();
        a_req_in = 0;
        repeat (3) tick();

        check32("strobe_q_empty", strobe_q.size(), 32'd0);
        check32("ack_q_empty", ack_q.size(), 32'd0);
        check32("fack_q_empty", fack_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
